// File: rtl/arbiter_pkg.sv
// Shared bus-arbiter encodings: FSM states, bus_grant mux selects, master IDs.
package arbiter_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GRANT_M1 = 2'd1;
  localparam logic [1:0] ST_GRANT_M2 = 2'd2;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M1   = 2'b01;
  localparam logic [1:0] GNT_M2   = 2'b10;

  localparam logic MASTER_M1 = 1'b0;
  localparam logic MASTER_M2 = 1'b1;

  function automatic logic [1:0] state_to_gnt(input logic [1:0] st);
    case (st)
      ST_GRANT_M1: return GNT_M1;
      ST_GRANT_M2: return GNT_M2;
      default:     return GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Grant-hold watchdog: counts cycles spent in one grant, flags the last allowed cycle.
// expired is combinational from the counter flop; TIMEOUT=0 disables it entirely.
module arb_watchdog
  import arbiter_pkg::*;
#(
  parameter int TIMEOUT  = 0,
  parameter int TO_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic in_grant,
  input  logic stay_grant,
  output logic expired
);

  logic [TO_WIDTH-1:0] cnt_q, cnt_d;

  // Restarts from zero on every grant entry and on every release.
  always_comb begin
    cnt_d = '0;
    if (in_grant && stay_grant) begin
      cnt_d = cnt_q + TO_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed grant cycles, so this cycle is the TIMEOUT-th one.
  assign expired = (TIMEOUT != 0) && in_grant && (cnt_q == TO_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/arbiter.sv
// Two-master round-robin bus arbiter; grant appears one edge after request in IDLE.
// Grant held until done, request drop or watchdog; one IDLE turnaround cycle between owners.
module arbiter
  import arbiter_pkg::*;
#(
  parameter int TIMEOUT  = 0,
  parameter int TO_WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m1_request,
  input  logic       m2_request,
  input  logic       transaction_done,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       busy,
  output logic [1:0] bus_grant
);

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] gnt_q, gnt_d;
  logic       expired;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (m1_request && m2_request) begin
          state_d = (last_q == MASTER_M2) ? ST_GRANT_M1 : ST_GRANT_M2;
        end else if (m1_request) begin
          state_d = ST_GRANT_M1;
        end else if (m2_request) begin
          state_d = ST_GRANT_M2;
        end
      end
      ST_GRANT_M1: begin
        if (transaction_done || !m1_request || expired) begin
          state_d = ST_IDLE;
          last_d  = MASTER_M1;
        end
      end
      ST_GRANT_M2: begin
        if (transaction_done || !m2_request || expired) begin
          state_d = ST_IDLE;
          last_d  = MASTER_M2;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    gnt_d = state_to_gnt(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= MASTER_M2;
      gnt_q   <= GNT_NONE;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

  arb_watchdog #(
    .TIMEOUT  (TIMEOUT),
    .TO_WIDTH (TO_WIDTH)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .in_grant   (state_q != ST_IDLE),
    .stay_grant (state_d != ST_IDLE),
    .expired    (expired)
  );

  assign m1_grant  = gnt_q[0];
  assign m2_grant  = gnt_q[1];
  assign busy      = |gnt_q;
  assign bus_grant = gnt_q;

endmodule

// File: tb/tb_arbiter.sv
// Bench for arbiter: one instance with an 8-cycle watchdog, one with it disabled,
// both driven by the same inputs and compared against an owner/round-robin model.
module tb_arbiter;

  logic clk;
  logic reset, m1_req, m2_req, done;

  logic       a_m1, a_m2, a_busy;
  logic [1:0] a_bg;
  logic       b_m1, b_m2, b_busy;
  logic [1:0] b_bg;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: owner 0=none 1=M1 2=M2, last owner, completed cycles in grant.
  int own_a = 0, last_a = 2, held_a = 0;
  int own_b = 0, last_b = 2, held_b = 0;

  arbiter #(.TIMEOUT(8), .TO_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .m1_request(m1_req), .m2_request(m2_req),
    .transaction_done(done), .m1_grant(a_m1), .m2_grant(a_m2),
    .busy(a_busy), .bus_grant(a_bg)
  );

  arbiter #(.TIMEOUT(0), .TO_WIDTH(16)) dut_b (
    .clk(clk), .reset(reset), .m1_request(m1_req), .m2_request(m2_req),
    .transaction_done(done), .m1_grant(b_m1), .m2_grant(b_m2),
    .busy(b_busy), .bus_grant(b_bg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_bg(input int own);
    return (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
  endfunction

  task automatic ref_step(input int to, inout int own, inout int last, inout int held);
    int req;
    if (reset) begin
      own = 0; last = 2; held = 0;
    end else if (own == 0) begin
      held = 0;
      if (m1_req && m2_req) own = (last == 1) ? 2 : 1;
      else if (m1_req)      own = 1;
      else if (m2_req)      own = 2;
    end else begin
      held = held + 1;
      req  = (own == 1) ? int'(m1_req) : int'(m2_req);
      if (done || req == 0 || (to != 0 && held >= to)) begin
        last = own; own = 0; held = 0;
      end
    end
  endtask

  task automatic drive(input logic r, input logic q1, input logic q2, input logic d);
    reset = r; m1_req = q1; m2_req = q2; done = d;
  endtask

  task automatic step();
    @(posedge clk);
    ref_step(8, own_a, last_a, held_a);
    ref_step(0, own_b, last_b, held_b);
    #1;
    check("a_bus_grant", a_bg, exp_bg(own_a));
    check("a_m1_grant", a_m1, own_a == 1);
    check("a_m2_grant", a_m2, own_a == 2);
    check("a_busy", a_busy, own_a != 0);
    check("b_bus_grant", b_bg, exp_bg(own_b));
    check("b_m1_grant", b_m1, own_b == 1);
    check("b_m2_grant", b_m2, own_b == 2);
    check("b_busy", b_busy, own_b != 0);
  endtask

  initial begin
    int len;
    bit started, ended;
    drive(1, 0, 0, 0);
    #1;
    step(); step();
    check("reset_bus_grant", a_bg, 2'b00);

    // First request: one-edge latency.
    drive(0, 1, 0, 0); step();
    check("t1_m1_grant", a_m1, 1'b1);
    check("t1_bus_grant", a_bg, 2'b01);

    // M2 request while M1 owns the bus must only wait.
    drive(0, 1, 1, 0); step(); step();
    check("t2_no_preempt", a_m2, 1'b0);

    // Done with both requesting: one idle cycle, then M2.
    drive(0, 1, 1, 1); step();
    check("t3_turnaround_busy", a_busy, 1'b0);
    drive(0, 1, 1, 0); step();
    check("t3_m2_bus_grant", a_bg, 2'b10);

    // Fresh reset: tie goes to M1, then to M2 after done.
    drive(1, 0, 0, 0); step();
    drive(0, 1, 1, 0); step();
    check("t4_first_tie_m1", a_bg, 2'b01);
    drive(0, 1, 1, 1); step();
    drive(0, 1, 1, 0); step();
    check("t4_second_tie_m2", a_bg, 2'b10);

    // Owner abort: M2 drops its request.
    drive(0, 1, 0, 0); step();
    check("t5_abort_idle", a_busy, 1'b0);
    step();

    // Watchdog: M1 holds forever, dut_a must release after 8 cycles.
    drive(1, 0, 0, 0); step();
    drive(0, 1, 0, 0);
    len = 0; started = 0; ended = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (a_m1 && !ended) begin
        started = 1; len++;
      end else if (started) begin
        ended = 1;
      end
    end
    check("t5_timeout_len", len, 8);
    check("t5_no_watchdog_held", b_m1, 1'b1);

    // Done held high across idle must not cut the next grant short.
    drive(0, 1, 1, 1); step(); step(); step(); step();

    // Reset while M2 owns the bus.
    drive(1, 0, 0, 0); step();
    drive(0, 0, 1, 0); step(); step();
    check("t6_pre_m2", a_m2, 1'b1);
    drive(1, 0, 1, 0); step();
    check("t6_reset_bus_grant", a_bg, 2'b00);
    check("t6_reset_busy", a_busy, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 65,
            $urandom_range(0, 99) < 65,
            $urandom_range(0, 99) < 20);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
